// File: rtl/serial_word_adder.sv
// Multi-precision serial add/subtract sequencer.
// One BW-bit slice per clock, carry chained slice to slice.
module serial_word_adder #(
    parameter int BW    = 4,
    parameter int WORDS = 4,
    localparam int N    = BW * WORDS,
    localparam int IW   = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         op_sub,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state;
    logic [IW-1:0]  idx;
    logic           carry;
    logic [N-1:0]   a_r;
    logic [N-1:0]   b_r;

    logic [BW-1:0]  a_sl;
    logic [BW-1:0]  b_sl;
    logic [BW:0]    sl_sum;
    logic           last;

    // The single reused slice adder
    always_comb begin
        a_sl   = a_r[idx*BW +: BW];
        b_sl   = b_r[idx*BW +: BW];
        sl_sum = {1'b0, a_sl} + {1'b0, b_sl} + {{BW{1'b0}}, carry};
        last   = (idx == IW'(WORDS - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r   <= a;
                        b_r   <= op_sub ? ~b : b;
                        carry <= op_sub ? 1'b1 : cin;
                        idx   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                        ovf   <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum[idx*BW +: BW] <= sl_sum[BW-1:0];
                    carry <= sl_sum[BW];
                    idx   <= idx + 1'b1;
                    if (last) begin
                        cout  <= sl_sum[BW];
                        // b_r already holds ~b when subtracting
                        ovf   <= (a_r[N-1] == b_r[N-1]) &&
                                 (sl_sum[BW-1] != a_r[N-1]);
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_adder.sv
// Directed bench for serial_word_adder (BW=4, WORDS=4).
// Table-driven vectors plus busy and mid-run reset sequences.
module tb_serial_word_adder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        op_sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int checks;
    int failures;

    serial_word_adder #(.BW(4), .WORDS(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op_sub (op_sub),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .cout   (cout),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vcin;
        logic        vsub;
        logic [15:0] esum;
        logic        ecout;
        logic        eovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Accept one op; returns edges from accept to the done-high cycle
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tc, input logic ts, output int lat);
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; op_sub = ts; start = 1'b1;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        cin = ~tc;
        op_sub = ~ts;
        while (!done && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    int lat;
    int ndone;
    int done_at[2];
    logic [15:0] done_sum[2];

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        start = 1'b0;
        op_sub = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;

        vecs[0] = '{16'h1234, 16'h0FED, 1'b0, 1'b0, 16'h2221, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[6] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsub, lat);
            check($sformatf("v%0d_lat", i), 32'(lat), 32'd4);
            check($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
            check($sformatf("v%0d_sum", i), 32'(sum), 32'(vecs[i].esum));
            check($sformatf("v%0d_cout", i), 32'(cout), 32'(vecs[i].ecout));
            check($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].eovf));
            @(negedge clk);
            check($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
            check($sformatf("v%0d_pulse", i), 32'(done), 32'd0);
            check($sformatf("v%0d_hold", i), 32'(sum), 32'(vecs[i].esum));
        end

        // Start held high, operands changing every cycle
        ndone = 0;
        done_at[0] = -1;
        done_at[1] = -1;
        done_sum[0] = '0;
        done_sum[1] = '0;
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            if (k > 0 && done) begin
                if (ndone < 2) begin
                    done_at[ndone] = k;
                    done_sum[ndone] = sum;
                end
                ndone++;
            end
            if (k < 12) begin
                start = 1'b1;
                op_sub = 1'b0;
                cin = 1'b0;
                a = 16'h1000 + 16'(k) * 16'h0111;
                b = 16'h0020 + 16'(k);
            end else begin
                start = 1'b0;
            end
        end
        check("busy_ndone", 32'(ndone), 32'd2);
        check("busy_at0", 32'(done_at[0]), 32'd5);
        check("busy_at1", 32'(done_at[1]), 32'd11);
        check("busy_sum0", 32'(done_sum[0]), 32'h1020);
        check("busy_sum1", 32'(done_sum[1]), 32'h168C);
        repeat (3) @(negedge clk);

        // Reset after two RUN slices
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; op_sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("mid_sum", 32'(sum), 32'h0033);
        #1 rst_n = 1'b0;
        #1;
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_done", 32'(done), 32'd0);
        check("ar_sum", 32'(sum), 32'd0);
        check("ar_cout", 32'(cout), 32'd0);
        check("ar_ovf", 32'(ovf), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("ar_quiet", 32'(ndone), 32'd0);
        do_op(16'hABCD, 16'h1111, 1'b1, 1'b0, lat);
        check("ar_lat", 32'(lat), 32'd4);
        check("ar_new_sum", 32'(sum), 32'hBCDF);
        check("ar_new_cout", 32'(cout), 32'd0);
        check("ar_new_ovf", 32'(ovf), 32'd0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
